// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a ready handshake, and holds one instruction for issue.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned branch targets into a sticky HALT state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        fetch_fault
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] ST_HALT  = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // Masking with a full-width AND keeps every Result bit in use when no alignment check exists.
    assign w_target = Result & ~32'h0000_0003;
    assign w_pc_inc = r_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
    logic w_fault_nxt;
    logic w_misaligned;

    assign w_misaligned = PCSrc && (Result[1:0] != 2'b00);
    assign fetch_fault  = r_fault;
`else
    assign fetch_fault  = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
`ifdef FETCH_ALIGN_CHECK_EN
        w_fault_nxt = r_fault;
`endif
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    w_instr_nxt = NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt    = PCSrc ? w_target : w_pc_inc;
                        w_state_nxt = ST_FETCH;
                    end
`else
                    w_pc_nxt    = PCSrc ? w_target : w_pc_inc;
                    w_state_nxt = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
`endif
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fault <= w_fault_nxt;
`endif
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == ST_ISSUE);
    assign Instr       = r_instr;
    assign PC          = r_pc;
    assign PCPlus8     = r_pc + 32'd8;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle ARM-subset processor: owns the program counter, requests instruction words from instruction memory over a ready handshake, and presents a registered 32-bit instruction to the control unit and datapath. It consumes the control unit's PCSrc and the writeback Result to redirect the PC on branches or writes to R15. It also supplies PC+8 for R15 operand reads.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned
- NOP_INSTR, 32'hE1A0_0000, value driven on Instr while no valid instruction is held (MOV R0,R0)

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- PCSrc  input  1  from control unit: take Result as next PC
- Result  input  32  writeback value, used as branch/R15 target
- stall  input  1  hold current instruction, no PC advance
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  word-aligned fetch address (= PC)
- imem_ready  input  1  memory has imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- Instr  output  32  registered instruction to control unit/datapath
- instr_valid  output  1  Instr is valid; downstream executes it this cycle
- PC  output  32  address of the instruction in Instr / being fetched
- PCPlus8  output  32  PC + 8, combinational from PC register
- fetch_fault  output  1  sticky misaligned-target flag (FETCH_ALIGN_CHECK_EN only; otherwise tied 0)

## Operation
- State machine: FETCH, ISSUE, HALT (HALT reachable only with FETCH_ALIGN_CHECK_EN).
- FETCH: imem_req=1, imem_addr=PC, instr_valid=0. On a rising edge with imem_ready=1: Instr <= imem_rdata, go to ISSUE. imem_ready=0: stay, hold address stable.
- ISSUE: imem_req=0, instr_valid=1. If stall=1: hold Instr, PC, state. If stall=0: PC <= PCSrc ? {Result[31:2],2'b00} : PC+4; Instr <= NOP_INSTR; go to FETCH.
- PCSrc and Result are sampled only on the ISSUE edge with stall=0; ignored in all other cycles.
- imem_ready while imem_req=0 is ignored; imem_rdata captured only in FETCH.
- PC arithmetic modulo 2^32: PC+4 from 32'hFFFF_FFFC wraps to 0; PCPlus8 likewise wraps.
- stall in FETCH has no effect (request stays pending).

## Timing
- Reset (asynchronous assert, any state, mid-fetch included): state=FETCH, PC=RESET_PC, Instr=NOP_INSTR, instr_valid=0, fetch_fault=0; imem_req=1 combinationally, so first request is visible in the first cycle after reset release.
- Minimum fetch latency: imem_ready high in the first FETCH cycle -> instr_valid high next cycle; 2 cycles per instruction minimum, plus one per imem_ready=0 cycle and per stall cycle.
- instr_valid high exactly one cycle per instruction when stall=0.
- PCPlus8 and imem_addr are combinational from the PC register; no added latency.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: at the ISSUE exit edge with PCSrc=1 and Result[1:0]!=0, PC is not updated, fetch_fault sets and stays set, state goes to HALT (imem_req=0, instr_valid=0) until reset.
- Not defined: Result[1:0] silently cleared, fetch_fault tied 0, HALT state not implemented.

## Test plan
- Reset release, imem_ready=1 always, stall=0, PCSrc=0 -> imem_addr 0x0, 0x4, 0x8 on every other cycle; Instr matches imem_rdata, instr_valid toggles 0/1.
- imem_ready held 0 for 3 cycles at PC=0x10 -> imem_req and imem_addr=0x10 stable 3 cycles; instr_valid rises one cycle after imem_ready=1; PCPlus8=0x18.
- ISSUE with Instr=32'hE3A0_002A, stall=1 for 2 cycles -> Instr, PC, instr_valid held 3 cycles total; then PC=old+4.
- ISSUE with PCSrc=1, Result=0x0000_0102 -> next imem_addr 0x100 (no macro); with FETCH_ALIGN_CHECK_EN, fetch_fault=1, imem_req=0 until reset.
- PC=0xFFFF_FFFC, PCSrc=0 -> next fetch address 0x0; PCPlus8 at 0xFFFF_FFFC is 0x4.
- reset asserted while imem_req=1 pending at PC=0x20 -> same cycle PC=RESET_PC, Instr=0xE1A0_0000, instr_valid=0.
